// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - shared RVFI data-memory record types and lane helpers
package rvfi_pkg;

  localparam int XLEN_DEFAULT = 32;

  function automatic int lanes(int xlen);
    return xlen / 8;
  endfunction

  localparam int NLANES = lanes(XLEN_DEFAULT);

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] addr;
    logic [NLANES-1:0]       rmask;
    logic [NLANES-1:0]       wmask;
    logic [XLEN_DEFAULT-1:0] rdata;
    logic [XLEN_DEFAULT-1:0] wdata;
  } dmem_rec_t;

  // Zero every byte whose lane bit is clear.
  function automatic logic [XLEN_DEFAULT-1:0] mask_lanes(
    input logic [XLEN_DEFAULT-1:0] data,
    input logic [NLANES-1:0]       mask
  );
    logic [XLEN_DEFAULT-1:0] out;
    out = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (mask[i]) out[8*i +: 8] = data[8*i +: 8];
    end
    return out;
  endfunction

endpackage

// File: rtl/rvfi_dmem_tracker_if.sv
// rtl/rvfi_dmem_tracker_if.sv - core data-memory handshake and retire signals
interface rvfi_dmem_tracker_if #(
  parameter int XLEN = 32
);

  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_rmask;
  logic [XLEN/8-1:0] mem_wmask;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              retire_valid;
  logic              retire_has_mem;
  logic              retire_trap;

  modport master (
    output mem_valid, mem_ready, mem_addr, mem_rmask, mem_wmask,
           mem_wdata, mem_rdata, retire_valid, retire_has_mem, retire_trap
  );

  modport slave (
    input mem_valid, mem_ready, mem_addr, mem_rmask, mem_wmask,
          mem_wdata, mem_rdata, retire_valid, retire_has_mem, retire_trap
  );

endinterface

// File: rtl/rvfi_sync_fifo.sv
// rtl/rvfi_sync_fifo.sv - circular FIFO of pending data-memory records
module rvfi_sync_fifo
  import rvfi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  dmem_rec_t push_data,
  input  logic      pop,
  output dmem_rec_t pop_data,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  dmem_rec_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop frees the slot a same-cycle push needs when full.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_dmem_tracker.sv
// rtl/rvfi_dmem_tracker.sv - pairs snooped data accesses with retiring instructions for RVFI
module rvfi_dmem_tracker
  import rvfi_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  rvfi_dmem_tracker_if.slave  bus,
  output logic                rvfi_valid,
  output logic [7:0]          rvfi_order,
  output logic                rvfi_trap,
  output logic [XLEN-1:0]     rvfi_mem_addr,
  output logic [XLEN/8-1:0]   rvfi_mem_rmask,
  output logic [XLEN/8-1:0]   rvfi_mem_wmask,
  output logic [XLEN-1:0]     rvfi_mem_rdata,
  output logic [XLEN-1:0]     rvfi_mem_wdata,
  output logic                err_overflow,
  output logic                err_underflow
);

  localparam int AW = $clog2(DEPTH);

  logic        xfer;
  logic        mem_retire;
  logic        bypass;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        unused_fifo_count;
  logic        overflow;
  logic        underflow;
  logic [7:0]  order_cnt;
  dmem_rec_t   cur;
  dmem_rec_t   head;
  dmem_rec_t   report;
  dmem_rec_t   rec_q;

  assign xfer       = bus.mem_valid && bus.mem_ready;
  assign mem_retire = bus.retire_valid && bus.retire_has_mem;
  assign bypass     = mem_retire && fifo_empty && xfer;
  assign fifo_pop   = mem_retire && !fifo_empty;
  assign fifo_push  = xfer && !bypass;
  assign overflow   = fifo_push && fifo_full && !fifo_pop;
  // A trapped access has no architectural effect, so a missing one is not an error.
  assign underflow  = mem_retire && fifo_empty && !xfer && !bus.retire_trap;
  assign unused_fifo_count = ^fifo_count;

  always_comb begin
    cur       = '0;
    cur.addr  = bus.mem_addr & ~(XLEN'(XLEN/8 - 1));
    cur.rmask = bus.mem_rmask;
    cur.wmask = bus.mem_wmask;
    cur.rdata = mask_lanes(bus.mem_rdata, bus.mem_rmask);
    cur.wdata = mask_lanes(bus.mem_wdata, bus.mem_wmask);
  end

  rvfi_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cur),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    report = '0;
    if (mem_retire) begin
      if (!fifo_empty) report = head;
      else if (xfer)   report = cur;
      if (bus.retire_trap) begin
        report.rmask = '0;
        report.wmask = '0;
        report.rdata = '0;
        report.wdata = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvfi_valid    <= 1'b0;
      rvfi_order    <= '0;
      rvfi_trap     <= 1'b0;
      rec_q         <= '0;
      order_cnt     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      rvfi_valid <= bus.retire_valid;
      rvfi_order <= bus.retire_valid ? order_cnt : 8'd0;
      rvfi_trap  <= bus.retire_valid && bus.retire_trap;
      rec_q      <= report;
      if (bus.retire_valid) order_cnt <= order_cnt + 8'd1;
      if (overflow)  err_overflow  <= 1'b1;
      if (underflow) err_underflow <= 1'b1;
    end
  end

  assign rvfi_mem_addr  = rec_q.addr;
  assign rvfi_mem_rmask = rec_q.rmask;
  assign rvfi_mem_wmask = rec_q.wmask;
  assign rvfi_mem_rdata = rec_q.rdata;
  assign rvfi_mem_wdata = rec_q.wdata;

endmodule

// File: tb/tb_rvfi_dmem_tracker.sv
// tb/tb_rvfi_dmem_tracker.sv - scoreboard testbench for rvfi_dmem_tracker
module tb_rvfi_dmem_tracker;
  import rvfi_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rvfi_valid;
  logic [7:0]  rvfi_order;
  logic        rvfi_trap;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] rvfi_mem_wdata;
  logic        err_overflow;
  logic        err_underflow;

  always #5 clk = ~clk;

  rvfi_dmem_tracker_if #(.XLEN(32)) bus ();

  rvfi_dmem_tracker #(
    .XLEN  (32),
    .DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_trap      (rvfi_trap),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .rvfi_mem_rdata (rvfi_mem_rdata),
    .rvfi_mem_wdata (rvfi_mem_wdata),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow)
  );

  typedef struct {
    logic        valid;
    logic [7:0]  order;
    logic        trap;
    dmem_rec_t   rec;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t      exp_q[$];
  dmem_rec_t pend[$];
  logic [7:0] m_order;
  logic      m_ovf;
  logic      m_unf;
  int        total = 0;
  int        bad = 0;

  function automatic dmem_rec_t mk(input logic [31:0] addr, input logic [3:0] rm,
                                   input logic [3:0] wm, input logic [31:0] rd,
                                   input logic [31:0] wd);
    dmem_rec_t r;
    r.addr  = {addr[31:2], 2'b00};
    r.rmask = rm;
    r.wmask = wm;
    r.rdata = '0;
    r.wdata = '0;
    for (int b = 0; b < 4; b++) begin
      if (rm[b]) r.rdata[8*b +: 8] = rd[8*b +: 8];
      if (wm[b]) r.wdata[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("valid", {31'd0, rvfi_valid}, {31'd0, e.valid});
    chk("order", {24'd0, rvfi_order}, {24'd0, e.order});
    chk("trap", {31'd0, rvfi_trap}, {31'd0, e.trap});
    chk("addr", rvfi_mem_addr, e.rec.addr);
    chk("rmask", {28'd0, rvfi_mem_rmask}, {28'd0, e.rec.rmask});
    chk("wmask", {28'd0, rvfi_mem_wmask}, {28'd0, e.rec.wmask});
    chk("rdata", rvfi_mem_rdata, e.rec.rdata);
    chk("wdata", rvfi_mem_wdata, e.rec.wdata);
    chk("err_overflow", {31'd0, err_overflow}, {31'd0, e.ovf});
    chk("err_underflow", {31'd0, err_underflow}, {31'd0, e.unf});
  endtask

  // Drive one cycle of inputs, predict the result, clock, then compare.
  task automatic drive(input logic mv, input logic mr, input logic [31:0] addr,
                       input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] rd, input logic [31:0] wd,
                       input logic rv, input logic hm, input logic tr);
    exp_t      e;
    exp_t      got;
    dmem_rec_t cur;
    logic      used;
    logic      xfer;
    bus.mem_valid      = mv;
    bus.mem_ready      = mr;
    bus.mem_addr       = addr;
    bus.mem_rmask      = rm;
    bus.mem_wmask      = wm;
    bus.mem_rdata      = rd;
    bus.mem_wdata      = wd;
    bus.retire_valid   = rv;
    bus.retire_has_mem = hm;
    bus.retire_trap    = tr;
    xfer    = mv && mr;
    cur     = mk(addr, rm, wm, rd, wd);
    used    = 1'b0;
    e.valid = 1'b0;
    e.order = 8'd0;
    e.trap  = 1'b0;
    e.rec   = '0;
    if (rv) begin
      e.valid = 1'b1;
      e.order = m_order;
      e.trap  = tr;
      m_order = m_order + 8'd1;
      if (hm) begin
        if (pend.size() > 0) e.rec = pend.pop_front();
        else if (xfer) begin
          e.rec = cur;
          used  = 1'b1;
        end else if (!tr) m_unf = 1'b1;
        if (tr) begin
          e.rec.rmask = '0;
          e.rec.wmask = '0;
          e.rec.rdata = '0;
          e.rec.wdata = '0;
        end
      end
    end
    if (xfer && !used) begin
      if (pend.size() < 4) pend.push_back(cur);
      else m_ovf = 1'b1;
    end
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_all(got);
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] rd);
    drive(1, 1, addr, 4'hF, 4'h0, rd, 32'h0, 0, 0, 0);
  endtask

  task automatic ret(input logic hm, input logic tr);
    drive(0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1, hm, tr);
  endtask

  task automatic reset_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, rvfi_valid}, 32'd0);
    chk({tag, "_order"}, {24'd0, rvfi_order}, 32'd0);
    chk({tag, "_addr"}, rvfi_mem_addr, 32'd0);
    chk({tag, "_rmask"}, {28'd0, rvfi_mem_rmask}, 32'd0);
    chk({tag, "_rdata"}, rvfi_mem_rdata, 32'd0);
    chk({tag, "_ovf"}, {31'd0, err_overflow}, 32'd0);
    chk({tag, "_unf"}, {31'd0, err_underflow}, 32'd0);
  endtask

  initial begin
    m_order = 8'd0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    bus.mem_valid = 0; bus.mem_ready = 0; bus.mem_addr = 0; bus.mem_rmask = 0;
    bus.mem_wmask = 0; bus.mem_wdata = 0; bus.mem_rdata = 0;
    bus.retire_valid = 0; bus.retire_has_mem = 0; bus.retire_trap = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_all_zero("reset");

    // Store then retire; stray rdata must be masked off.
    drive(1, 1, 32'h1006, 4'h0, 4'hC, 32'hFFFF_FFFF, 32'hAABBCCDD, 0, 0, 0);
    ret(1, 0);
    chk("st_addr", rvfi_mem_addr, 32'h1004);
    chk("st_wmask", {28'd0, rvfi_mem_wmask}, 32'hC);
    chk("st_wdata", rvfi_mem_wdata, 32'hAABB0000);
    chk("st_rdata", rvfi_mem_rdata, 32'h0);
    chk("st_order", {24'd0, rvfi_order}, 32'd0);

    // Stalled request is not a transfer.
    drive(1, 0, 32'h3000, 4'hF, 4'h0, 32'h5555_5555, 32'h0, 0, 0, 0);

    // Bypass: transfer and memory retire in the same cycle on an empty FIFO.
    drive(1, 1, 32'h20, 4'hF, 4'h0, 32'h12345678, 32'h0, 1, 1, 0);
    chk("byp_rdata", rvfi_mem_rdata, 32'h12345678);
    chk("byp_addr", rvfi_mem_addr, 32'h20);
    chk("byp_order", {24'd0, rvfi_order}, 32'd1);

    // Fill, overflow, then full simultaneous push+pop.
    load(32'h0, 32'hA0A0A0A0);
    load(32'h4, 32'hA1A1A1A1);
    load(32'h8, 32'hA2A2A2A2);
    load(32'hC, 32'hA3A3A3A3);
    chk("pre_ovf", {31'd0, err_overflow}, 32'd0);
    load(32'h10, 32'hA4A4A4A4);
    chk("ovf_set", {31'd0, err_overflow}, 32'd1);
    drive(1, 1, 32'h14, 4'hF, 4'h0, 32'hA5A5A5A5, 32'h0, 1, 1, 0);
    chk("ord0_addr", rvfi_mem_addr, 32'h0);
    ret(1, 0);
    chk("ord1_addr", rvfi_mem_addr, 32'h4);
    ret(1, 0);
    chk("ord2_addr", rvfi_mem_addr, 32'h8);
    ret(1, 0);
    chk("ord3_addr", rvfi_mem_addr, 32'hC);
    ret(1, 0);
    chk("ord4_addr", rvfi_mem_addr, 32'h14);
    chk("ord4_rdata", rvfi_mem_rdata, 32'hA5A5A5A5);

    // Underflow on empty FIFO, sticky afterwards.
    chk("pre_unf", {31'd0, err_underflow}, 32'd0);
    ret(1, 0);
    chk("unf_valid", {31'd0, rvfi_valid}, 32'd1);
    chk("unf_rmask", {28'd0, rvfi_mem_rmask}, 32'd0);
    chk("unf_set", {31'd0, err_underflow}, 32'd1);
    idle();
    chk("unf_sticky", {31'd0, err_underflow}, 32'd1);
    chk("idle_valid", {31'd0, rvfi_valid}, 32'd0);

    // Order counter walks through a full wrap.
    for (int i = 0; i < 257; i++) ret(0, 0);

    // Trapped load retire consumes its entry but hides lanes and data.
    load(32'h41, 32'hDEADBEEF);
    ret(1, 1);
    chk("trap_flag", {31'd0, rvfi_trap}, 32'd1);
    chk("trap_rmask", {28'd0, rvfi_mem_rmask}, 32'd0);
    chk("trap_addr", rvfi_mem_addr, 32'h40);
    load(32'h50, 32'h0BADF00D);
    ret(1, 0);
    chk("after_trap_addr", rvfi_mem_addr, 32'h50);

    // Reset mid-stream with two entries still queued.
    load(32'h60, 32'h11111111);
    load(32'h64, 32'h22222222);
    drive(1, 1, 32'h68, 4'h3, 4'h0, 32'h33333333, 32'h0, 1, 1, 0);
    chk("pre_rst_addr", rvfi_mem_addr, 32'h60);
    bus.mem_valid = 0; bus.retire_valid = 0; bus.retire_has_mem = 0;
    reset = 1'b1;
    #1;
    reset_all_zero("midrst");
    pend.delete();
    exp_q.delete();
    m_order = 8'd0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ret(1, 0);
    chk("rst_unf", {31'd0, err_underflow}, 32'd1);
    chk("rst_order", {24'd0, rvfi_order}, 32'd0);
    chk("rst_addr", rvfi_mem_addr, 32'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rvfi_dmem_tracker.md
Name: rvfi_dmem_tracker

Overview:
- Producer side of the RVFI memory fields, for a single retire channel (NRET=1).
- Snoops the core's data-memory request/response handshake and queues each completed access.
- Pairs each queued access with the retiring instruction that issued it.
- Drives rvfi_valid/rvfi_order/rvfi_mem_* into the downstream formal checkers, one cycle after retire.

Parameters:
- XLEN, 32, data/address width; byte lanes = XLEN/8.
- DEPTH, 4, pending-access FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  core data request valid.
- mem_ready  in  1  memory accepts/completes; transfer when mem_valid && mem_ready.
- mem_addr  in  XLEN  byte address of request.
- mem_rmask  in  XLEN/8  byte lanes read.
- mem_wmask  in  XLEN/8  byte lanes written.
- mem_wdata  in  XLEN  write data, lane-aligned.
- mem_rdata  in  XLEN  read data, valid in the transfer cycle.
- retire_valid  in  1  one instruction retires this cycle.
- retire_has_mem  in  1  retiring instruction performed one data access.
- retire_trap  in  1  retiring instruction trapped.
- rvfi_valid  out  1  registered retire strobe.
- rvfi_order  out  8  retire index.
- rvfi_trap  out  1  registered retire_trap.
- rvfi_mem_addr  out  XLEN  word-aligned access address.
- rvfi_mem_rmask  out  XLEN/8  read lanes.
- rvfi_mem_wmask  out  XLEN/8  write lanes.
- rvfi_mem_rdata  out  XLEN  read data.
- rvfi_mem_wdata  out  XLEN  write data.
- err_overflow  out  1  sticky: an access was dropped because the FIFO was full.
- err_underflow  out  1  sticky: a memory retire found no access.

Behaviour:
- Reset (async assert): all outputs 0, order counter 0, FIFO empty, both error flags 0. Reset mid-operation discards pending entries.
- Capture:
  - On a transfer, push {addr & ~(XLEN/8-1), rmask, wmask, rdata masked to rmask lanes, wdata masked to wmask lanes}.
  - Non-enabled lanes are stored as 0.
  - A transfer with rmask == 0 and wmask == 0 is still pushed.
- Retire:
  - On retire_valid, the next cycle has rvfi_valid=1, rvfi_order=current count, and rvfi_trap=retire_trap.
  - The count increments by 1 and wraps 255->0.
  - With no retire_valid, rvfi_valid=0 next cycle and all rvfi_mem_* fields are 0.
- Pop:
  - If retire_valid && retire_has_mem, pop the FIFO head into rvfi_mem_*.
  - Bypass: if the FIFO is empty and a transfer occurs in the same cycle, the transfer data goes directly to the outputs and is not pushed.
- Underflow: retire_valid && retire_has_mem with FIFO empty and no bypass -> err_underflow=1 next cycle; rvfi_mem_* all 0; rvfi_valid still 1.
- Trap: retire_trap=1 with has_mem pops an entry if one is available, but drives rvfi_mem_rmask/wmask/rdata/wdata = 0 (addr still reported). No underflow error is raised on trap.
- Overflow: a push when FIFO count == DEPTH with no simultaneous pop -> drop the access, err_overflow=1 next cycle. When the FIFO is full, a simultaneous push and pop succeed.
- FIFO: circular read/write pointers with log2(DEPTH)+1 bit count; FIFO ordering is preserved.
- Latency: retire -> rvfi_valid exactly 1 cycle; transfer -> earliest rvfi report 1 cycle (bypass).
- Error flags clear only on reset.

Decomposition:
- Shared package rvfi_pkg holds:
  - XLEN default.
  - Lane count function.
  - Packed struct dmem_rec_t {addr, rmask, wmask, rdata, wdata} shared with the checkers.
  - Lane-mask helper function mask_lanes(data, mask).
- One natural sub-module: rvfi_sync_fifo (DEPTH x dmem_rec_t, push/pop/full/empty/count, async active-high reset).

Test Plan:
- Store then retire: transfer addr=0x1006, wmask=0b1100, wdata=0xAABBCCDD, one cycle later retire_has_mem -> rvfi_mem_addr=0x1004, wmask=0b1100, wdata=0xAABB0000, order=0.
- Bypass: FIFO empty; read transfer addr=0x20, rmask=0xF, rdata=0x12345678 in the same cycle as retire_has_mem -> next cycle rvfi_mem_rdata=0x12345678; FIFO stays empty.
- Ordering/full: 4 loads at 0x0, 0x4, 0x8, 0xC, then 5th transfer at 0x10 with no retire -> err_overflow=1; then 4 retires report addrs 0x0, 0x4, 0x8, 0xC in order.
- Underflow: retire_has_mem with empty FIFO and no transfer -> rvfi_valid=1, masks 0, err_underflow=1 (sticky).
- Order wrap and trap: 256 non-mem retires -> order 0..255, then 0. Trapped load retire with a queued entry -> rvfi_trap=1, rmask=0, entry consumed.
- Reset mid-stream: 2 entries queued, assert reset for 1 cycle -> all outputs 0 immediately. Next retire_has_mem -> err_underflow=1, order=0.
